ffe_tone_synth: RTL and testbench

//  Square-wave synthesiser; the output side of the fundamental-frequency estimator.

---
 rtl/ffe_tone_synth_pkg.sv | 7 +
 rtl/ffe_tone_synth_if.sv | 14 +
 rtl/ffe_period_shadow.sv | 40 ++++
 rtl/ffe_tone_synth.sv | 76 +++++++
 tb/tb_ffe_tone_synth.sv | 137 +++++++++++++
 5 files changed

// File: rtl/ffe_tone_synth_pkg.sv
// ffe_pkg: shared widths and FSM encoding for the tone synthesiser
package ffe_pkg;
  localparam int DATA_W = 14;
  localparam int PER_W  = 32;
  localparam int OCT_W  = 2;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_POS = 2'd1, ST_NEG = 2'd2} state_t;
endpackage

// File: rtl/ffe_tone_synth_if.sv
// ffe_tone_synth_if: request and sample bus between the estimator side and the synthesiser
interface ffe_tone_synth_if;
  import ffe_pkg::*;
  logic [PER_W-1:0]  periodo;
  logic              periodo_valid;
  logic [OCT_W-1:0]  octava;
  logic [DATA_W-2:0] amp;
  logic              en;
  logic [DATA_W-1:0] data_out;
  logic              cruce_cero;
  logic              activo;
  modport master (output periodo, periodo_valid, octava, amp, en, input data_out, cruce_cero, activo);
  modport slave  (input periodo, periodo_valid, octava, amp, en, output data_out, cruce_cero, activo);
endinterface

// File: rtl/ffe_period_shadow.sv
// ffe_period_shadow: half-period computation, last-wins pending request and same-cycle bypass
module ffe_period_shadow
  import ffe_pkg::*;
(
  input  logic              CLK_IN,
  input  logic              RST_N_IN,
  input  logic [PER_W-1:0]  periodo_i,
  input  logic              valid_i,
  input  logic [OCT_W-1:0]  octava_i,
  input  logic [DATA_W-2:0] amp_i,
  input  logic              consume_i,
  output logic [PER_W-1:0]  load_half_o,
  output logic [DATA_W-2:0] load_amp_o,
  output logic              load_req_o,
  output logic              load_ok_o
);
  logic [PER_W-1:0]  new_half, pend_half_q;
  logic [DATA_W-2:0] pend_amp_q;
  logic              pend_flag_q, pend_flag_d;
  assign new_half    = (periodo_i >> octava_i) >> 1;
  assign load_half_o = valid_i ? new_half : pend_half_q;
  assign load_amp_o  = valid_i ? amp_i : pend_amp_q;
  assign load_req_o  = valid_i | pend_flag_q;
  assign load_ok_o   = load_req_o && (load_half_o != '0);
  // A request taken in the same cycle it arrives is never left pending
  assign pend_flag_d = !consume_i && (valid_i || pend_flag_q);
  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      pend_half_q <= '0;
      pend_amp_q  <= '0;
      pend_flag_q <= 1'b0;
    end else begin
      pend_flag_q <= pend_flag_d;
      if (valid_i) begin
        pend_half_q <= new_half;
        pend_amp_q  <= amp_i;
      end
    end
  end
endmodule

// File: rtl/ffe_tone_synth.sv
// ffe_tone_synth: square-wave regenerator; parameter changes land only at zero crossings
module ffe_tone_synth
  import ffe_pkg::*;
(
  input logic CLK_IN,
  input logic RST_N_IN,
  ffe_tone_synth_if.slave bus
);
  state_t            state_q, state_d;
  logic [PER_W-1:0]  cnt_q, cnt_d, act_half_q, act_half_d, load_half;
  logic [DATA_W-2:0] act_amp_q, act_amp_d, load_amp;
  logic [DATA_W-1:0] data_q, data_d, amp_ext;
  logic              cruce_q, cruce_d, consume, load_req, load_ok, boundary;
  ffe_period_shadow u_shadow (
    .CLK_IN(CLK_IN), .RST_N_IN(RST_N_IN),
    .periodo_i(bus.periodo), .valid_i(bus.periodo_valid), .octava_i(bus.octava), .amp_i(bus.amp),
    .consume_i(consume),
    .load_half_o(load_half), .load_amp_o(load_amp), .load_req_o(load_req), .load_ok_o(load_ok)
  );
  assign boundary = (state_q != ST_IDLE) && (cnt_q == act_half_q - PER_W'(1));
  assign amp_ext  = {1'b0, act_amp_d};
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    act_half_d = act_half_q;
    act_amp_d  = act_amp_q;
    cruce_d    = 1'b0;
    consume    = 1'b0;
    if (state_q == ST_IDLE) begin
      if (bus.en && load_ok) begin
        consume    = 1'b1;
        act_half_d = load_half;
        act_amp_d  = load_amp;
        cnt_d      = '0;
        state_d    = ST_POS;
      end
    end else if (!boundary) begin
      cnt_d = cnt_q + PER_W'(1);
    end else if (!bus.en || (load_req && !load_ok)) begin
      // Disabling keeps any pending request for the next enable
      consume = bus.en;
      cnt_d   = '0;
      state_d = ST_IDLE;
    end else begin
      consume = load_req;
      if (load_req) begin
        act_half_d = load_half;
        act_amp_d  = load_amp;
      end
      cnt_d   = '0;
      state_d = (state_q == ST_POS) ? ST_NEG : ST_POS;
      cruce_d = 1'b1;
    end
    data_d = (state_d == ST_POS) ? amp_ext : (state_d == ST_NEG) ? -amp_ext : '0;
  end
  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      act_half_q <= '0;
      act_amp_q  <= '0;
      data_q     <= '0;
      cruce_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      act_half_q <= act_half_d;
      act_amp_q  <= act_amp_d;
      data_q     <= data_d;
      cruce_q    <= cruce_d;
    end
  end
  assign bus.data_out   = data_q;
  assign bus.cruce_cero = cruce_q;
  assign bus.activo     = state_q != ST_IDLE;
endmodule

// File: tb/tb_ffe_tone_synth.sv
// tb_ffe_tone_synth: directed and random stimulus against a countdown model of the synthesiser
module tb_ffe_tone_synth;
  import ffe_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  ffe_tone_synth_if bus ();
  ffe_tone_synth dut (.CLK_IN(clk), .RST_N_IN(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  bit m_run, m_cz, m_pf;
  int m_sign, m_left;
  int unsigned m_half, m_amp, m_ph, m_pa;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_cz = 0; m_pf = 0; m_left = 0; m_sign = 1;
  endtask

  // Tone model: remaining-cycles countdown per half, sign as +1/-1
  task automatic model_edge();
    int unsigned vh, rh, ra;
    bit rp;
    vh = bus.periodo / (32'd2 << bus.octava);
    rp = bus.periodo_valid || m_pf;
    rh = bus.periodo_valid ? vh : m_ph;
    ra = bus.periodo_valid ? int'(bus.amp) : m_pa;
    m_cz = 0;
    if (!m_run) begin
      if (bus.en && rp && rh != 0) begin
        m_run = 1; m_sign = 1; m_half = rh; m_amp = ra; m_left = int'(rh); m_pf = 0;
      end else if (bus.periodo_valid) begin
        m_ph = vh; m_pa = bus.amp; m_pf = 1;
      end
    end else begin
      m_left--;
      if (m_left > 0 || !bus.en) begin
        if (m_left == 0) m_run = 0;
        if (bus.periodo_valid) begin m_ph = vh; m_pa = bus.amp; m_pf = 1; end
      end else if (rp && rh == 0) begin
        m_run = 0; m_pf = 0;
      end else begin
        if (rp) begin m_half = rh; m_amp = ra; m_pf = 0; end
        m_sign = -m_sign; m_left = int'(m_half); m_cz = 1;
      end
    end
  endtask

  task automatic check_outs();
    int v;
    logic [13:0] e;
    v = m_run ? m_sign * int'(m_amp) : 0;
    e = v[13:0];
    check("data_out", 32'(bus.data_out), 32'(e));
    check("cruce_cero", 32'(bus.cruce_cero), 32'(m_cz));
    check("activo", 32'(bus.activo), 32'(m_run));
  endtask

  task automatic cyc(input bit v, input int unsigned per, input int o, input int a, input bit e);
    @(negedge clk);
    bus.periodo_valid = v; bus.periodo = per; bus.octava = o[1:0]; bus.amp = a[12:0]; bus.en = e;
    @(posedge clk);
    model_edge();
    #1 check_outs();
  endtask

  task automatic idle(input int n, input bit e);
    repeat (n) cyc(0, 0, 0, 0, e);
  endtask

  task automatic to_boundary();
    for (int i = 0; i < 300 && !(m_run && m_left == 1); i++) idle(1, 1);
    check("align_boundary", 32'(m_run && m_left == 1), 32'd1);
  endtask

  initial begin
    int a;
    bus.periodo_valid = 0; bus.periodo = 0; bus.octava = 0; bus.amp = 0; bus.en = 0;
    model_reset();
    #3 check_outs();
    @(negedge clk) rst_n = 1'b1;
    // Basic tone: half = 50, amplitude 1000
    cyc(1, 100, 0, 1000, 1);
    idle(99, 1);
    // Mid-half request waits for the crossing; request at the crossing takes effect at once
    idle(20, 1);
    a = int'($urandom_range(1, 8191));
    cyc(1, 40, 0, a, 1);
    idle(110, 1);
    to_boundary();
    cyc(1, 60, 0, 2000, 1);
    idle(70, 1);
    // Octave shift and the one-cycle half
    to_boundary();
    cyc(1, 100, 1, int'($urandom_range(1, 8191)), 1);
    idle(60, 1);
    to_boundary();
    cyc(1, 2, 0, 77, 1);
    idle(12, 1);
    // Invalid request while running stops at the next crossing without a pulse
    cyc(1, 1, 0, 500, 1);
    idle(6, 1);
    cyc(1, 1, 0, 500, 1);
    idle(4, 1);
    cyc(1, 3, 1, 500, 1);
    idle(4, 1);
    // Enable dropped mid-half, then a request while disabled starts on re-enable
    cyc(1, 100, 0, 3000, 1);
    idle(10, 1);
    idle(60, 0);
    cyc(1, 80, 0, 0, 0);
    idle(3, 0);
    idle(90, 1);
    // Async reset in the negative half
    for (int i = 0; i < 300 && !(m_run && m_sign < 0); i++) idle(1, 1);
    check("reach_neg", 32'(m_run && m_sign < 0), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_outs();
    @(negedge clk) rst_n = 1'b1;
    idle(10, 1);
    // Random traffic
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 60), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 8191)), $urandom_range(0, 9) != 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
